// File: rtl/ysyx_22050598_defines.sv
// Shared encodings for the AXI read arbiter: FSM states, AXI constants, owner IDs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22050598_defines;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Owner IDs double as the AXI ARID/RID used for the burst.
  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  // Cacheable lines are 16-byte aligned.
  function automatic logic [63:0] line_addr(input logic [63:0] a);
    return {a[63:4], 4'b0000};
  endfunction

endpackage

// File: rtl/ysyx_22050598_rr_arb2.sv
// Two-way grant select (bit0 = IFU, bit1 = LSU), fixed LSU priority or round-robin.
// Latency: purely combinational.
// Backpressure: none; caller samples the grant only when it can accept a new burst.
module ysyx_22050598_rr_arb2
  import ysyx_22050598_defines::*;
#(
  parameter bit FIXED_PRIO = 1'b1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_vld_o,
  output logic       gnt_id_o
);

  // On conflict pick LSU (fixed) or whoever was not granted last (round-robin).
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_id_o  = ID_IFU;
    if (req_i == 2'b11) begin
      gnt_id_o = FIXED_PRIO ? ID_LSU : ~last_i;
    end else if (req_i[1]) begin
      gnt_id_o = ID_LSU;
    end
  end

endmodule

// File: rtl/ysyx_22050598_axi_rd_arbiter.sv
// Shares one AXI4 AR/R port between IFU and LSU, one burst at a time, returns a 128-bit line.
// Latency: req -> arvalid +1 -> beats -> one-cycle ready pulse (4 cycles with a zero-wait slave).
// Backpressure: requesters hold req until their ready; AR fields held until arready; rready high in DATA.
module ysyx_22050598_axi_rd_arbiter
  import ysyx_22050598_defines::*;
#(
  parameter int LINE_BEATS = 2,
  parameter int LSU_PRIO   = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req,
  input  logic [63:0]   ifu_addr,
  output logic          ifu_ready,
  output logic [127:0]  ifu_rdata,
  input  logic          lsu_req,
  input  logic [63:0]   lsu_addr,
  input  logic          lsu_is_device,
  output logic          lsu_ready,
  output logic [127:0]  lsu_rdata,
  output logic          rd_err,
  output logic          m_arid,
  output logic [63:0]   m_araddr,
  output logic [7:0]    m_arlen,
  output logic [2:0]    m_arsize,
  output logic [1:0]    m_arburst,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic          m_rid,
  input  logic [63:0]   m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rlast,
  input  logic          m_rvalid,
  output logic          m_rready
);

  localparam int               CNT_W    = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LINE_BEATS - 1);
  localparam logic [7:0]       LINE_LEN = 8'(LINE_BEATS - 1);
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LIM  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  rd_state_e        state_q, state_d;
  logic             owner_q, owner_d;
  logic             dev_q, dev_d;
  logic [63:0]      addr_q, addr_d;
  logic [127:0]     line_q, line_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             gnt_vld, gnt_id;
  logic             timeout_hit;
  logic [CNT_W-1:0] exp_last;
  logic             done;

  ysyx_22050598_rr_arb2 #(
    .FIXED_PRIO (LSU_PRIO != 0)
  ) u_arb (
    .req_i     ({lsu_req, ifu_req}),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  assign timeout_hit = (TIMEOUT != 0) && (tmr_q == TMR_LIM);
  assign exp_last    = dev_q ? '0 : CNT_MAX;

  // Next-state, datapath capture and AXI handshake outputs.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    dev_d     = dev_q;
    addr_d    = addr_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    last_d    = last_q;
    tmr_d     = tmr_q;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state_q)
      // Ready pulses only exist in DONE, so a grant here never coincides with one.
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_id;
          last_d  = gnt_id;
          dev_d   = (gnt_id == ID_LSU) && lsu_is_device;
          addr_d  = (gnt_id == ID_LSU) ? lsu_addr : ifu_addr;
          line_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          tmr_d   = '0;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          tmr_d   = '0;
          state_d = ST_DATA;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          tmr_d = '0;
          if (m_rid != owner_q) begin
            // Beat for someone else: drop it but report the protocol error.
            err_d = 1'b1;
          end else begin
            for (int b = 0; b < LINE_BEATS; b++) begin
              if (cnt_q == CNT_W'(b)) line_d[64*b +: 64] = m_rdata;
            end
            if (m_rresp != AXI_RESP_OKAY) err_d = 1'b1;
            if (m_rlast) begin
              if (cnt_q != exp_last) err_d = 1'b1;
              state_d = ST_DONE;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset also abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= ID_IFU;
      dev_q   <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= ID_IFU;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dev_q   <= dev_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
    end
  end

  assign m_arid    = owner_q;
  assign m_araddr  = dev_q ? addr_q : line_addr(addr_q);
  assign m_arlen   = dev_q ? 8'd0 : LINE_LEN;
  assign m_arsize  = AXI_SIZE_8B;
  assign m_arburst = AXI_BURST_INCR;

  assign done      = (state_q == ST_DONE);
  assign ifu_ready = done && (owner_q == ID_IFU);
  assign lsu_ready = done && (owner_q == ID_LSU);
  assign rd_err    = done && err_q;
  assign ifu_rdata = line_q;
  assign lsu_rdata = dev_q ? {2{line_q[63:0]}} : line_q;

endmodule

// File: tb/tb_ysyx_22050598_axi_rd_arbiter.sv
// Scoreboard bench for the AXI read arbiter with a scripted AXI read slave.
// Latency: n/a.
// Backpressure: slave stalls arready / withholds beats per transaction plan.
module tb_ysyx_22050598_axi_rd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         ifu_req, lsu_req, lsu_is_device;
  logic [63:0]  ifu_addr, lsu_addr;
  logic         ifu_ready, lsu_ready, rd_err;
  logic [127:0] ifu_rdata, lsu_rdata;
  logic         m_arid, m_arvalid, m_arready, m_rid, m_rlast, m_rvalid, m_rready;
  logic [63:0]  m_araddr, m_rdata;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst, m_rresp;

  // Second instance with a short timeout and a slave that never answers.
  logic         t_ifu_req;
  logic         t_ifu_ready, t_lsu_ready, t_rd_err;
  logic [127:0] t_ifu_rdata, t_lsu_rdata;
  logic         t_arid, t_arvalid, t_rready;
  logic [63:0]  t_araddr;
  logic [7:0]   t_arlen;
  logic [2:0]   t_arsize;
  logic [1:0]   t_arburst;

  ysyx_22050598_axi_rd_arbiter #(.LINE_BEATS(2), .LSU_PRIO(1), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_is_device(lsu_is_device),
    .lsu_ready(lsu_ready), .lsu_rdata(lsu_rdata), .rd_err(rd_err),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  ysyx_22050598_axi_rd_arbiter #(.LINE_BEATS(2), .LSU_PRIO(0), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst),
    .ifu_req(t_ifu_req), .ifu_addr(64'h8000_0100), .ifu_ready(t_ifu_ready), .ifu_rdata(t_ifu_rdata),
    .lsu_req(1'b0), .lsu_addr(64'h0), .lsu_is_device(1'b0),
    .lsu_ready(t_lsu_ready), .lsu_rdata(t_lsu_rdata), .rd_err(t_rd_err),
    .m_arid(t_arid), .m_araddr(t_araddr), .m_arlen(t_arlen), .m_arsize(t_arsize),
    .m_arburst(t_arburst), .m_arvalid(t_arvalid), .m_arready(1'b0),
    .m_rid(1'b0), .m_rdata(64'h0), .m_rresp(2'b00), .m_rlast(1'b0),
    .m_rvalid(1'b0), .m_rready(t_rready)
  );

  typedef struct {
    logic        id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [63:0] seed;
    int          delay;
    bit          bad;
    int          errb;
    bit          shrt;
    bit          stall;
  } ar_exp_t;

  typedef struct {
    logic         who;
    logic [127:0] data;
    logic         err;
  } rd_exp_t;

  ar_exp_t ar_q[$];
  rd_exp_t sb_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, iss_cyc = 0, last_lat = -1;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a request and record what the slave and the requester should see.
  task automatic issue(input bit who, input logic [63:0] addr, input bit dev, input logic [63:0] seed,
                       input int delay, input bit bad, input int errb, input bit shrt, input bit stall);
    ar_exp_t a;
    rd_exp_t r;
    a.id = who; a.addr = dev ? addr : {addr[63:4], 4'h0}; a.len = dev ? 8'd0 : 8'd1;
    a.seed = seed; a.delay = delay; a.bad = bad; a.errb = errb; a.shrt = shrt; a.stall = stall;
    ar_q.push_back(a);
    if (!stall) begin
      r.who = who;
      if (dev)       r.data = {seed, seed};
      else if (shrt) r.data = {64'h0, seed};
      else           r.data = {seed * 2, seed};
      r.err = bad || (errb >= 0) || shrt;
      sb_q.push_back(r);
    end
    if (who) begin lsu_req = 1'b1; lsu_addr = addr; lsu_is_device = dev; end
    else     begin ifu_req = 1'b1; ifu_addr = addr; end
  endtask

  // One cycle; checks any completion pulse against the scoreboard head.
  task automatic tick();
    rd_exp_t r;
    @(posedge clk); #1;
    cyc++;
    if (ifu_ready || lsu_ready) begin
      chk_eq("one_rdy", ifu_ready & lsu_ready, 0);
      chk_eq("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        last_lat = cyc - iss_cyc;
        chk_eq("rdy_who", lsu_ready, r.who);
        chk_eq("rdata", r.who ? lsu_rdata : ifu_rdata, r.data);
        chk_eq("rd_err", rd_err, r.err);
      end
      if (ifu_ready) ifu_req = 1'b0;
      if (lsu_ready) lsu_req = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (sb_q.size() != 0 || ar_q.size() != 0); i++) tick();
    chk_eq("drain_sb", sb_q.size(), 0);
    chk_eq("drain_ar", ar_q.size(), 0);
    tick(); tick();
  endtask

  // Scripted AXI read slave.
  initial begin : axi_slave
    ar_exp_t p;
    int nb, k;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_arvalid && rst) begin
        chk_eq("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) begin
          p = ar_q.pop_front();
          for (int i = 0; i < p.delay; i++) begin
            @(posedge clk); #1;
            chk_eq("ar_hold_vld", m_arvalid, 1);
            chk_eq("ar_hold_addr", m_araddr, p.addr);
          end
          chk_eq("arid", m_arid, p.id);
          chk_eq("araddr", m_araddr, p.addr);
          chk_eq("arlen", m_arlen, p.len);
          chk_eq("arsize", m_arsize, 3'b011);
          chk_eq("arburst", m_arburst, 2'b01);
          m_arready = 1'b1;
          @(posedge clk); #1;
          m_arready = 1'b0;
          if (!p.stall) begin
            nb = p.shrt ? 1 : int'(p.len) + 1;
            if (p.bad) nb++;
            k = 0;
            for (int b = 0; b < nb; b++) begin
              if (p.bad && b == 1) begin
                m_rid = ~p.id; m_rdata = 64'hDEAD_BEEF_DEAD_BEEF; m_rresp = 2'b00; m_rlast = 1'b0;
              end else begin
                m_rid = p.id; m_rdata = p.seed * (k + 1);
                m_rresp = (k == p.errb) ? 2'b10 : 2'b00;
                m_rlast = p.shrt || (k == int'(p.len));
                k++;
              end
              m_rvalid = 1'b1;
              @(posedge clk); #1;
            end
            m_rvalid = 1'b0; m_rlast = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    bit seen;
    int n;
    rst = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0; lsu_is_device = 1'b0;
    ifu_addr = '0; lsu_addr = '0; t_ifu_req = 1'b0;
    repeat (3) tick();
    chk_eq("rst_arvalid", m_arvalid, 0);
    chk_eq("rst_rready", m_rready, 0);
    chk_eq("rst_ifu_ready", ifu_ready, 0);
    chk_eq("rst_lsu_ready", lsu_ready, 0);
    chk_eq("rst_rd_err", rd_err, 0);
    rst = 1'b1;
    tick();

    // Lone IFU line fetch, zero-wait slave: ready four cycles after the request.
    iss_cyc = cyc;
    issue(1'b0, 64'h8000_0008, 1'b0, 64'h1111_1111_1111_1111, 0, 1'b0, -1, 1'b0, 1'b0);
    tick();
    chk_eq("arvalid_c1", m_arvalid, 1);
    drain();
    chk_eq("ifu_latency", last_lat, 4);

    // Simultaneous requests: LSU wins, IFU served next.
    issue(1'b1, 64'h8000_1000, 1'b0, 64'h0303_0303_0303_0303, 0, 1'b0, -1, 1'b0, 1'b0);
    issue(1'b0, 64'h8000_2010, 1'b0, 64'h0505_0505_0505_0505, 0, 1'b0, -1, 1'b0, 1'b0);
    drain();

    // Device read at exact address, single beat replicated.
    issue(1'b1, 64'ha000_03f8, 1'b1, 64'h0000_0000_dead_00f8, 0, 1'b0, -1, 1'b0, 1'b0);
    drain();

    // SLVERR on second beat.
    issue(1'b0, 64'h8000_0040, 1'b0, 64'h0101_0202_0303_0404, 0, 1'b0, 1, 1'b0, 1'b0);
    drain();

    // Foreign-rid beat injected mid-burst.
    issue(1'b1, 64'h8000_0080, 1'b0, 64'h0a0a_0b0b_0c0c_0d0d, 0, 1'b1, -1, 1'b0, 1'b0);
    drain();

    // arready withheld for ten cycles.
    issue(1'b0, 64'h8000_0123, 1'b0, 64'h0007_0007_0007_0007, 10, 1'b0, -1, 1'b0, 1'b0);
    drain();

    // Burst ends early with rlast on the first beat.
    issue(1'b1, 64'h8000_0200, 1'b0, 64'h0042_0042_0042_0042, 0, 1'b0, -1, 1'b1, 1'b0);
    drain();

    // Reset while waiting for data.
    issue(1'b0, 64'h8000_0300, 1'b0, 64'h0, 0, 1'b0, -1, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (m_rready) seen = 1'b1;
    end
    chk_eq("stall_in_data", seen, 1);
    tick(); tick();
    rst = 1'b0; ifu_req = 1'b0;
    tick();
    chk_eq("rstmid_arvalid", m_arvalid, 0);
    chk_eq("rstmid_rready", m_rready, 0);
    chk_eq("rstmid_ifu_ready", ifu_ready, 0);
    rst = 1'b1;
    tick();
    chk_eq("rstmid_ar_consumed", ar_q.size(), 0);

    // Normal traffic after the mid-burst reset.
    issue(1'b1, 64'h8000_0400, 1'b0, 64'h0909_0909_0909_0909, 0, 1'b0, -1, 1'b0, 1'b0);
    drain();

    // Short-timeout instance: unanswered AR must end in an error pulse.
    t_ifu_req = 1'b1;
    seen = 1'b0; n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      n++;
      if (t_ifu_ready) begin
        seen = 1'b1;
        chk_eq("to_err", t_rd_err, 1);
        chk_eq("to_rdata", t_ifu_rdata, 0);
        chk_eq("to_latency", n, 9);
        t_ifu_req = 1'b0;
      end else if (n >= 2) begin
        chk_eq("to_arvalid", t_arvalid, 1);
      end
    end
    chk_eq("to_seen", seen, 1);
    tick();
    chk_eq("to_idle_arvalid", t_arvalid, 0);
    chk_eq("to_idle_ready", t_ifu_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
